multiword_adder_ctrl: RTL and testbench
=======================================

# multiword_adder_ctrl

Sequential controller that adds two WIDTH-bit operands plus carry-in using a single 4-bit ripple-carry adder slice. The slice is reused once per nibble, least significant first, with the carry registered between passes. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It trades WIDTH/4 cycles of latency for one 4-bit adder's area.

## Interface
- WIDTH, default 16: operand/result width; must be a multiple of 4 and at least 4.
- NIB = WIDTH/4 (localparam): number of slice passes.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  controller can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- Sum  output  WIDTH  A+B+Cin modulo 2^WIDTH.
- Cout  output  1  carry out of bit WIDTH-1.

## Operation
- States are IDLE, RUN and DONE.
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid & in_ready: register A, B, Cin; clear the Sum register; nibble index idx=0; carry register = Cin; go to RUN.
- RUN
  - in_ready=0, out_valid=0.
  - Each cycle the slice gets A[4*idx+:4], B[4*idx+:4] and the carry register.
  - The slice sum is written to Sum[4*idx+:4], the slice carry-out goes to the carry register, and idx increments.
  - On the pass where idx==NIB-1, go to DONE.
- DONE
  - out_valid=1; Sum and Cout are held stable; Cout = carry register.
  - On out_ready go to IDLE.
  - While out_ready=0, stay in DONE; Sum/Cout must not change.
- Operands are captured at acceptance. Later changes on A/B/Cin have no effect on the operation in flight.
- in_valid while not in IDLE is ignored; in_ready=0 in that case. There is no accept in the same cycle as a result drain; a new operation is accepted one cycle after DONE exits.
- Arithmetic:
  - Unsigned. Overflow is reported only via Cout; no saturation.
  - idx is a ceil(log2(NIB)) bit counter, minimum 1 bit.
  - For WIDTH=4 (NIB=1), RUN lasts exactly one cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - state=IDLE, in_ready=1 after deassertion, out_valid=0, Sum=0, Cout=0, idx=0, carry register=0.
  - The partial result is discarded. No output glitch to out_valid=1 is permitted.

## Timing
- All state and outputs are registered on the rising clk edge, except in_ready, which is decoded from state only and never from in_valid.
- Acceptance edge E0. RUN occupies edges E1..E_NIB. out_valid is high in the cycle after edge E_NIB; for WIDTH=16 that is 4 cycles after acceptance.
- Throughput: one operation per NIB+2 cycles at best (accept, NIB passes, drain).
- A result is consumed on the edge where out_valid & out_ready are both high; out_valid drops and in_ready rises on that edge.
- The slice is combinational. The critical path is the 4-bit ripple plus the nibble mux, independent of WIDTH.

## Structure
- The shared package multiword_adder_pkg holds:
  - the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - NIBBLE_W=4.
- One sub-module: the existing 4-bit ripple-carry adder slice (ports A, B, Cin, Sum, Cout), instantiated once.
- The controller contains the FSM, operand registers, idx counter, carry register and Sum register.

## Test plan
All scenarios use WIDTH=16 unless stated.
- 0x0000+0x0000, Cin=0 -> Sum=0x0000, Cout=0, out_valid exactly 4 cycles after accept.
- 0xFFFF+0x0001, Cin=0 -> Sum=0x0000, Cout=1 (carry propagates through all 4 passes).
- 0x1234+0x4321, Cin=1 -> Sum=0x5556, Cout=0; 0xFFFF+0xFFFF, Cin=1 -> Sum=0xFFFF, Cout=1.
- Backpressure and input isolation:
  - Hold out_ready=0 for 5 cycles in DONE -> Sum/Cout stable and in_ready=0 throughout.
  - Change A/B mid-RUN -> result unaffected.
  - Assert in_valid in RUN -> no capture.
- Reset and back-to-back:
  - Assert rst_n=0 on the second RUN cycle -> all outputs 0 immediately, in_ready=1 after release.
  - Next operation 0x00FF+0x0001 -> Sum=0x0100, Cout=0.
- WIDTH=4 and back-to-back:
  - 0xF+0x1, Cin=0 -> Sum=0x0, Cout=1 after 1 RUN cycle.
  - Two operations with in_valid held high -> second accepted exactly one cycle after the first drain.

Source files
------------

// File: rtl/multiword_adder_pkg.sv
// Shared definitions for the nibble-serial multiword adder.
// Contents: the controller state encoding and the width of the adder slice.
package multiword_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : multiword_adder_pkg

// File: rtl/multiword_adder_ctrl_slice.sv
// 4-bit ripple-carry adder slice, purely combinational.
// Ports:
//   A, B  - nibble operands
//   Cin   - carry into bit 0
//   Sum   - A + B + Cin, low nibble
//   Cout  - carry out of bit 3
module multiword_adder_ctrl_slice
  import multiword_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Cin,
  output logic [NIBBLE_W-1:0] Sum,
  output logic                Cout
);

  logic carry;

  // Carry ripples bit by bit through a single procedural chain.
  always_comb begin
    carry = Cin;
    Sum   = '0;
    for (int i = 0; i < int'(NIBBLE_W); i++) begin
      Sum[i] = A[i] ^ B[i] ^ carry;
      carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
    end
    Cout = carry;
  end

endmodule : multiword_adder_ctrl_slice

// File: rtl/multiword_adder_ctrl.sv
// Sequential WIDTH-bit adder that reuses one 4-bit slice per nibble, LSB first,
// with the carry held in a register between passes.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid/in_ready   - operand handshake (in_ready decoded from state)
//   A, B, Cin           - operands, captured on acceptance
//   out_valid/out_ready - result handshake
//   Sum, Cout           - registered result, stable while out_valid is high
module multiword_adder_ctrl
  import multiword_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH-1:0]    a_sh, b_sh;
  logic [NIBBLE_W-1:0] slice_sum;
  logic                slice_cout;

  // Nibble select: shift by idx*4 so the current nibble lands in the low bits.
  assign a_sh = a_q >> {idx_q, 2'b00};
  assign b_sh = b_q >> {idx_q, 2'b00};

  multiword_adder_ctrl_slice u_slice (
    .A    (a_sh[NIBBLE_W-1:0]),
    .B    (b_sh[NIBBLE_W-1:0]),
    .Cin  (carry_q),
    .Sum  (slice_sum),
    .Cout (slice_cout)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          sum_d   = '0;
          idx_d   = '0;
          cout_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum was cleared on accept, so OR-ing the nibble in is a write.
        sum_d   = sum_q | (WIDTH'(slice_sum) << {idx_q, 2'b00});
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule : multiword_adder_ctrl

// File: tb/tb_multiword_adder_ctrl.sv
// Directed bench for multiword_adder_ctrl at WIDTH=16 and WIDTH=4.
module tb_multiword_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=16 instance
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0, sum16;
  logic        cin16 = 1'b0, cout16;

  // WIDTH=4 instance
  logic        in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0, sum4;
  logic        cin4 = 1'b0, cout4;

  int n_cmp = 0;
  int n_err = 0;

  multiword_adder_ctrl #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .Cin(cin16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .Sum(sum16), .Cout(cout16)
  );

  multiword_adder_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .A(a4), .B(b4), .Cin(cin4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .Sum(sum4), .Cout(cout4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One WIDTH=16 operation: accept, optional disturbance in RUN, optional
  // backpressure in DONE, then drain.
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic [15:0] es, input logic ec,
                      input int hold, input bit disturb);
    int cnt;
    @(negedge clk);
    check_eq("idle_in_ready", 32'(in_ready16), 32'd1);
    a16 = a; b16 = b; cin16 = cin; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("run_in_ready", 32'(in_ready16), 32'd0);
    if (disturb) begin
      a16 = ~a; b16 = 16'h5A5A; cin16 = ~cin; in_valid16 = 1'b1;
    end else begin
      in_valid16 = 1'b0;
    end
    cnt = 0;
    while (!out_valid16 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    in_valid16 = 1'b0;
    check_eq("latency", 32'(cnt), 32'd4);
    check_eq("sum", 32'(sum16), 32'(es));
    check_eq("cout", 32'(cout16), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("bp_valid", 32'(out_valid16), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready16), 32'd0);
      check_eq("bp_sum", 32'(sum16), 32'(es));
      check_eq("bp_cout", 32'(cout16), 32'(ec));
    end
    out_ready16 = 1'b1;
    @(negedge clk);
    out_ready16 = 1'b0;
    check_eq("drain_valid", 32'(out_valid16), 32'd0);
    check_eq("drain_in_ready", 32'(in_ready16), 32'd1);
  endtask

  initial begin
    // Reset state
    #2;
    check_eq("rst_valid", 32'(out_valid16), 32'd0);
    check_eq("rst_sum", 32'(sum16), 32'd0);
    check_eq("rst_cout", 32'(cout16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_in_ready", 32'(in_ready16), 32'd1);

    op16(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 1'b0);
    op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0, 1'b0);
    op16(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 0, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 5, 1'b0);

    // Reset on the second RUN cycle; first pass has already written 0x3.
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; cin16 = 1'b0; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(out_valid16), 32'd0);
    check_eq("midrst_sum", 32'(sum16), 32'd0);
    check_eq("midrst_cout", 32'(cout16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("postrst_in_ready", 32'(in_ready16), 32'd1);
    check_eq("postrst_valid", 32'(out_valid16), 32'd0);

    op16(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 0, 1'b0);

    // WIDTH=4, single op: one RUN cycle
    @(negedge clk);
    a4 = 4'hF; b4 = 4'h1; cin4 = 1'b0; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    check_eq("w4_run_valid", 32'(out_valid4), 32'd0);
    check_eq("w4_run_in_ready", 32'(in_ready4), 32'd0);
    @(negedge clk);
    check_eq("w4_valid", 32'(out_valid4), 32'd1);
    check_eq("w4_sum", 32'(sum4), 32'h0);
    check_eq("w4_cout", 32'(cout4), 32'd1);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    check_eq("w4_drain", 32'(out_valid4), 32'd0);

    // WIDTH=4 back-to-back with in_valid and out_ready held high
    a4 = 4'h3; b4 = 4'h4; cin4 = 1'b0; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk);                      // E0 accept
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h9; cin4 = 1'b1;   // offered during RUN, must wait
    @(negedge clk);                      // after E1: DONE
    check_eq("b2b_valid1", 32'(out_valid4), 32'd1);
    check_eq("b2b_sum1", 32'(sum4), 32'h7);
    check_eq("b2b_cout1", 32'(cout4), 32'd0);
    @(negedge clk);                      // after E2: drained, IDLE
    check_eq("b2b_idle_valid", 32'(out_valid4), 32'd0);
    check_eq("b2b_idle_ready", 32'(in_ready4), 32'd1);
    @(negedge clk);                      // after E3: second accepted
    check_eq("b2b_accept2", 32'(in_ready4), 32'd0);
    @(negedge clk);                      // after E4: second result
    in_valid4 = 1'b0;
    check_eq("b2b_valid2", 32'(out_valid4), 32'd1);
    check_eq("b2b_sum2", 32'(sum4), 32'h3);
    check_eq("b2b_cout2", 32'(cout4), 32'd1);
    @(negedge clk);
    out_ready4 = 1'b0;
    check_eq("b2b_drain2", 32'(out_valid4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_multiword_adder_ctrl
